// File: rtl/gearbox_tx_nw.sv
// gearbox_tx_nw: 66b -> OUT_W-bit TX gearbox between the 64b/66b encoder and the PMA serialiser
//   clk, nreset (async, active-low)
//   valid_i, head_i, data_i : block input, block = {data_i, head_i}
//   accept_o                : block taken this cycle when valid_i=1
//   data_v_o, data_o        : output word, bit 0 transmitted first
//   underflow_o             : sticky underflow flag, only with GEARBOX_TX_UNDERFLOW_EN defined
module gearbox_tx_nw #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int OUT_W  = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              accept_o,
  output logic              data_v_o,
`ifdef GEARBOX_TX_UNDERFLOW_EN
  output logic              underflow_o,
`endif
  output logic [OUT_W-1:0]  data_o
);
  localparam int BLOCK_W = HEAD_W + DATA_W;
  localparam int CNT_W = $clog2(BLOCK_W + OUT_W);
  localparam int BUF_W = BLOCK_W + OUT_W - 1;
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] BLK_C = CNT_W'(BLOCK_W);
  if (OUT_W < 8 || OUT_W > DATA_W) begin : g_bad_out_w
    $error("gearbox_tx_nw: OUT_W must satisfy 8 <= OUT_W <= DATA_W");
  end
  logic [BLOCK_W-1:0] res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BUF_W-1:0]   sh;
  // res_q is zero above cnt_q, so OR-ing the shifted block in cannot corrupt residual bits
  assign sh = (BUF_W'({data_i, head_i}) << cnt_q) | BUF_W'(res_q);
  assign accept_o = cnt_q < OUT_C;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      res_q    <= '0;
      cnt_q    <= '0;
      data_o   <= '0;
      data_v_o <= 1'b0;
    end else if (accept_o && valid_i) begin
      data_o   <= sh[OUT_W-1:0];
      data_v_o <= 1'b1;
      res_q    <= BLOCK_W'(sh >> OUT_W);
      cnt_q    <= cnt_q + BLK_C - OUT_C;
    end else if (!accept_o) begin
      data_o   <= res_q[OUT_W-1:0];
      data_v_o <= 1'b1;
      res_q    <= res_q >> OUT_W;
      cnt_q    <= cnt_q - OUT_C;
    end else
      data_v_o <= 1'b0;
`ifdef GEARBOX_TX_UNDERFLOW_EN
  logic seen_q;
  logic uf;
  // an underflow only counts once the line has carried data since reset
  assign uf = accept_o && !valid_i && (seen_q || data_v_o);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      seen_q      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      seen_q      <= seen_q | data_v_o;
      underflow_o <= underflow_o | uf;
    end
  a_no_double_underflow: assert property (@(posedge clk) disable iff (!nreset) uf |=> valid_i);
`endif
endmodule

// File: tb/tb_gearbox_tx_nw.sv
// tb_gearbox_tx_nw: random-stimulus bench for three gearbox widths against a bit-queue reference model
module tb_gearbox_tx_nw;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [2:0]  valid = '0;
  logic [65:0] blk [3];
  wire  [2:0]  acc, dv;
  wire  [15:0] d16;
  wire  [31:0] d32;
  wire  [63:0] d64;
`ifdef GEARBOX_TX_UNDERFLOW_EN
  wire  [2:0]  uf;
`endif
  int checks = 0;
  int errors = 0;
  bit          q [3][$];
  logic [63:0] exp_data [3];
  logic        exp_dv [3];
  logic        exp_acc;
  bit          rst_done = 0;
  always #5 clk = ~clk;
  gearbox_tx_nw #(.OUT_W(16)) u16 (
    .clk(clk), .nreset(nreset), .valid_i(valid[0]), .head_i(blk[0][1:0]), .data_i(blk[0][65:2]),
    .accept_o(acc[0]), .data_v_o(dv[0]),
`ifdef GEARBOX_TX_UNDERFLOW_EN
    .underflow_o(uf[0]),
`endif
    .data_o(d16));
  gearbox_tx_nw #(.OUT_W(32)) u32 (
    .clk(clk), .nreset(nreset), .valid_i(valid[1]), .head_i(blk[1][1:0]), .data_i(blk[1][65:2]),
    .accept_o(acc[1]), .data_v_o(dv[1]),
`ifdef GEARBOX_TX_UNDERFLOW_EN
    .underflow_o(uf[1]),
`endif
    .data_o(d32));
  gearbox_tx_nw #(.OUT_W(64)) u64 (
    .clk(clk), .nreset(nreset), .valid_i(valid[2]), .head_i(blk[2][1:0]), .data_i(blk[2][65:2]),
    .accept_o(acc[2]), .data_v_o(dv[2]),
`ifdef GEARBOX_TX_UNDERFLOW_EN
    .underflow_o(uf[2]),
`endif
    .data_o(d64));
  function automatic int w(int i);
    return 16 << i;
  endfunction
  function automatic logic [63:0] dout(int i);
    return i == 0 ? 64'(d16) : i == 1 ? 64'(d32) : d64;
  endfunction
  function automatic logic [63:0] cnt(int i);
    return i == 0 ? 64'(u16.cnt_q) : i == 1 ? 64'(u32.cnt_q) : 64'(u64.cnt_q);
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_data%0d", i), dout(i), 64'd0);
      check($sformatf("rst_dv%0d", i), 64'(dv[i]), 64'd0);
      check($sformatf("rst_acc%0d", i), 64'(acc[i]), 64'd1);
      check($sformatf("rst_cnt%0d", i), cnt(i), 64'd0);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      blk[i] = {$urandom(), $urandom(), 2'($urandom())};
      exp_data[i] = '0;
      exp_dv[i] = 1'b0;
    end
    valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    nreset = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (!rst_done && (c == 4000 || (c >= 3000 && q[1].size() == 34))) begin
        nreset = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
          q[i].delete();
          exp_data[i] = '0;
          exp_dv[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        rst_done = 1;
      end
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dv%0d", i), 64'(dv[i]), 64'(exp_dv[i]));
        check($sformatf("data%0d", i), dout(i), exp_data[i]);
        check($sformatf("cnt%0d", i), cnt(i), 64'(q[i].size()));
      end
      for (int i = 0; i < 3; i++) begin
        if (c < 70) begin
          valid[i] = 1'b1;
          blk[i] = {64'hfedcba9876543210, 2'b10};
        end else if (c >= 200 && c < 203) begin
          valid[i] = 1'b0;
        end else begin
          valid[i] = c < 400 ? 1'b1 : ($urandom_range(0, 9) < 7);
          blk[i] = {$urandom(), $urandom(), 2'($urandom())};
        end
        exp_acc = q[i].size() < w(i);
        check($sformatf("acc%0d", i), 64'(acc[i]), 64'(exp_acc));
        if (exp_acc && valid[i])
          for (int b = 0; b < 66; b++) q[i].push_back(blk[i][b]);
        if (!exp_acc || valid[i]) begin
          exp_data[i] = '0;
          for (int b = 0; b < w(i); b++) exp_data[i][b] = q[i].pop_front();
          exp_dv[i] = 1'b1;
        end else
          exp_dv[i] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
